// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames (start, 8 data bits LSB first, stop), CLKS_PER_BIT clocks per bit.
// Defining UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   // CLKS_PER_BIT must be at least 2.
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       data_q, data_nxt;
   logic             tx_nxt, busy_nxt, done_nxt;
   logic             bit_last;

   assign bit_last = (cnt == CNT_LAST);

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         idx    <= '0;
         data_q <= '0;
         tx     <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         data_q <= data_nxt;
         tx     <= tx_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
      end
   end

   // Next state; tx_nxt is the line level for the cycle after this edge
   always_comb begin
      state_nxt = state;
      cnt_nxt   = bit_last ? '0 : cnt + CNT_W'(1);
      idx_nxt   = idx;
      data_nxt  = data_q;
      tx_nxt    = tx;
      busy_nxt  = busy;
      done_nxt  = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            tx_nxt   = 1'b1;
            busy_nxt = 1'b0;
            if (tx_start) begin
               data_nxt  = tx_data;
               idx_nxt   = '0;
               state_nxt = START;
               tx_nxt    = 1'b0;
               busy_nxt  = 1'b1;
            end
         end
         START: begin
            if (bit_last) begin
               state_nxt = DATA;
               tx_nxt    = data_q[0];
            end
         end
         DATA: begin
            if (bit_last) begin
               if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nxt = PARITY;
                  tx_nxt    = ^data_q;
`else
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
`endif
               end else begin
                  idx_nxt = idx + 3'd1;
                  tx_nxt  = data_q[idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_last) begin
               state_nxt = STOP;
               tx_nxt    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (bit_last) begin
               state_nxt = IDLE;
               tx_nxt    = 1'b1;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
            busy_nxt  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx (CLKS_PER_BIT=4): per-cycle check against a time-indexed frame model,
// plus a table of hand-written line sequences and directed corner-case sequences.
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_start = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx, busy, done;

   uart_tx #(.CLKS_PER_BIT(CPB)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx       (tx),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int n_done_seen = 0;

   // Reference model: a frame is a list of line levels, each held CPB cycles after acceptance
   logic        m_active = 1'b0;
   logic        m_done = 1'b0;
   int          m_t = 0;
   logic [10:0] m_bits = '1;

   typedef struct {
      logic [7:0] data;
      logic [9:0] seq;   // line levels in time order, MSB first: start, d0..d7, stop
      logic       par;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (!rst_n) begin
         m_active = 1'b0;
         m_done   = 1'b0;
      end else if (m_active) begin
         m_t++;
         if (m_t == FRAME) begin
            m_active = 1'b0;
            m_done   = 1'b1;
         end
      end else begin
         m_done = 1'b0;
         if (tx_start) begin
            m_active = 1'b1;
            m_t      = 0;
            m_bits   = '1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[1+i] = tx_data[i];
            if (NB == 11) m_bits[9] = ^tx_data;
         end
      end
      #1;
      cyc++;
      if (done === 1'b1) n_done_seen++;
      check("tx", 32'(tx), m_active ? 32'(m_bits[m_t / CPB]) : 32'd1);
      check("busy", 32'(busy), 32'(m_active));
      check("done", 32'(done), 32'(m_done));
   endtask

   function automatic logic exp_line(input vec_t v, input int k);
      if (NB == 11) begin
         if (k < 9) return v.seq[9-k];
         if (k == 9) return v.par;
         return 1'b1;
      end
      return v.seq[9-k];
   endfunction

   // Send one table entry; optionally pulse tx_start with 8'hFF at frame cycle glitch_at
   task automatic send_entry(input vec_t v, input int glitch_at);
      int d0;
      tx_start = 1'b1;
      tx_data  = v.data;
      cycle();
      d0 = n_done_seen;
      for (int t = 0; t < FRAME; t++) begin
         if (t % CPB == 1) check("line_bit", 32'(tx), 32'(exp_line(v, t / CPB)));
         tx_start = (t == glitch_at);
         tx_data  = (t == glitch_at) ? 8'hFF : 8'($urandom);
         cycle();
      end
      tx_start = 1'b0;
      check("done_at_frame_end", 32'(done), 32'd1);
      check("busy_at_frame_end", 32'(busy), 32'd0);
      check("one_done_per_frame", 32'(n_done_seen - d0), 32'd1);
   endtask

   initial begin
      int d0;
      tbl[0] = '{8'hA5, 10'b0_10100101_1, 1'b0};
      tbl[1] = '{8'h0F, 10'b0_11110000_1, 1'b0};
      tbl[2] = '{8'h55, 10'b0_10101010_1, 1'b0};
      tbl[3] = '{8'h3C, 10'b0_00111100_1, 1'b0};
      tbl[4] = '{8'h07, 10'b0_11100000_1, 1'b1};
      tbl[5] = '{8'h03, 10'b0_11000000_1, 1'b0};
      tbl[6] = '{8'h80, 10'b0_00000001_1, 1'b1};
      tbl[7] = '{8'hFF, 10'b0_11111111_1, 1'b0};

      // Reset with tx_start asserted, then idle
      rst_n    = 1'b0;
      tx_start = 1'b1;
      tx_data  = 8'hA5;
      repeat (3) cycle();
      rst_n    = 1'b1;
      tx_start = 1'b0;
      repeat (20) cycle();
      check("idle_tx", 32'(tx), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);

      // Table of frames
      for (int i = 0; i < 8; i++) begin
         send_entry(tbl[i], -1);
         repeat (2) cycle();
      end

      // tx_start with other data while busy is ignored
      send_entry(tbl[1], 10);
      d0 = n_done_seen;
      repeat (FRAME + 5) cycle();
      check("no_queued_frame", 32'(n_done_seen - d0), 32'd0);

      // Back-to-back with tx_start held high
      tx_start = 1'b1;
      tx_data  = 8'h55;
      cycle();
      repeat (FRAME) cycle();
      check("b2b_done1", 32'(done), 32'd1);
      check("b2b_busy_low", 32'(busy), 32'd0);
      cycle();
      check("b2b_start2_tx", 32'(tx), 32'd0);
      check("b2b_start2_busy", 32'(busy), 32'd1);
      repeat (FRAME) cycle();
      check("b2b_done2", 32'(done), 32'd1);
      tx_start = 1'b0;
      cycle();
      check("b2b_idle", 32'(busy), 32'd0);
      repeat (3) cycle();

      // Reset mid-frame
      tx_start = 1'b1;
      tx_data  = 8'h3C;
      cycle();
      tx_start = 1'b0;
      repeat (15) cycle();
      rst_n = 1'b0;
      cycle();
      check("midrst_tx", 32'(tx), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      d0 = n_done_seen;
      repeat (FRAME + 5) cycle();
      check("midrst_no_done", 32'(n_done_seen - d0), 32'd0);
      send_entry(tbl[3], -1);
      repeat (2) cycle();

      // Randomized traffic including occasional resets
      for (int i = 0; i < 1500; i++) begin
         rst_n    = ($urandom_range(0, 299) != 0);
         tx_start = ($urandom_range(0, 3) == 0);
         tx_data  = 8'($urandom);
         cycle();
      end
      rst_n    = 1'b1;
      tx_start = 1'b0;
      repeat (FRAME + 5) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
